// File: rtl/message_scroll_ctrl_if.sv
// Host-side bundle for the message scroller: buffer write port, run control
// and the four digit characters plus status going out to the LED driver.
interface message_scroll_ctrl_if #(
  parameter int MSG_LEN = 16,
  parameter int CHAR_W  = 4
);
  localparam int AW = $clog2(MSG_LEN);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic [4:0]        len_cfg;
  logic              start;
  logic              stop;
  logic [CHAR_W-1:0] dig3;
  logic [CHAR_W-1:0] dig2;
  logic [CHAR_W-1:0] dig1;
  logic [CHAR_W-1:0] dig0;
  logic              busy;
  logic              wrap;

  modport master (
    output wr_en, wr_addr, wr_data, len_cfg, start, stop,
    input  dig3, dig2, dig1, dig0, busy, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_cfg, start, stop,
    output dig3, dig2, dig1, dig0, busy, wrap
  );
endinterface

// File: rtl/message_scroll_ctrl.sv
// Scrolls a 4-character window across a host-written message buffer and
// presents it to the four character inputs of the 7-segment LED driver.
//
//   state | meaning
//   IDLE  | window frozen at current offset, tick counter held at 0
//   RUN   | tick counter runs; offset advances every TICK_DIV clocks
module message_scroll_ctrl #(
  parameter int MSG_LEN  = 16,
  parameter int TICK_DIV = 25000000,
  parameter int CHAR_W   = 4
) (
  input logic clk,
  input logic reset,
  message_scroll_ctrl_if.slave bus
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LEN_MIN  = LW'(4);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MSG_LEN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CHAR_W-1:0] msg_buf [MSG_LEN];
  logic [AW-1:0]     offset;
  logic [CW-1:0]     cnt;
  logic [LW-1:0]     active_len;
  logic [LW-1:0]     len_clamped;
  logic              at_last;

  // Window index (base + k) mod len; base < len and k <= 3 < len, so one
  // conditional subtract is enough even for non-power-of-two lengths.
  function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] base,
                                            input logic [1:0]    k,
                                            input logic [LW-1:0] len);
    logic [LW-1:0] sum;
    sum = {1'b0, base} + {{(LW-2){1'b0}}, k};
    if (sum >= len) sum = sum - len;
    return sum[AW-1:0];
  endfunction

  // Clamp the requested message length into 4..MSG_LEN.
  always_comb begin
    len_clamped = LW'(bus.len_cfg);
    if (int'(bus.len_cfg) < 4)            len_clamped = LEN_MIN;
    else if (int'(bus.len_cfg) > MSG_LEN) len_clamped = LEN_MAX;
  end

  assign at_last = ({1'b0, offset} == (active_len - LW'(1)));

  // Scroll sequencer: stop beats start, start beats a pending scroll step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      offset     <= '0;
      cnt        <= '0;
      active_len <= LEN_MIN;
      bus.busy   <= 1'b0;
      bus.wrap   <= 1'b0;
    end else begin
      bus.wrap <= 1'b0;
      if (bus.stop) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        cnt      <= '0;
      end else if (bus.start) begin
        state      <= RUN;
        bus.busy   <= 1'b1;
        offset     <= '0;
        cnt        <= '0;
        active_len <= len_clamped;
      end else if (state == RUN) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          if (at_last) begin
            offset   <= '0;
            bus.wrap <= 1'b1;
          end else begin
            offset <= offset + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Message buffer; host writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= '0;
    end else if (bus.wr_en) begin
      msg_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered window, one clock behind offset and buffer changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dig3 <= '0;
      bus.dig2 <= '0;
      bus.dig1 <= '0;
      bus.dig0 <= '0;
    end else begin
      bus.dig3 <= msg_buf[win_idx(offset, 2'd0, active_len)];
      bus.dig2 <= msg_buf[win_idx(offset, 2'd1, active_len)];
      bus.dig1 <= msg_buf[win_idx(offset, 2'd2, active_len)];
      bus.dig0 <= msg_buf[win_idx(offset, 2'd3, active_len)];
    end
  end
endmodule

// File: tb/tb_message_scroll_ctrl.sv
// Self-checking bench for message_scroll_ctrl with a short scroll period.
module tb_message_scroll_ctrl;
  localparam int MSG_LEN  = 16;
  localparam int TICK_DIV = 4;
  localparam int CHAR_W   = 4;

  typedef struct {
    int d3, d2, d1, d0, busy, wrap;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;
  exp_t sb_q[$];

  // reference model state
  int m_buf [MSG_LEN];
  int m_off, m_cnt, m_len, m_run;

  message_scroll_ctrl_if #(.MSG_LEN(MSG_LEN), .CHAR_W(CHAR_W)) bus ();

  message_scroll_ctrl #(
    .MSG_LEN (MSG_LEN),
    .TICK_DIV(TICK_DIV),
    .CHAR_W  (CHAR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict the outputs for the coming edge, advance the model, clock the
  // DUT and compare against the popped prediction.
  task automatic step();
    exp_t e;
    int   req;
    if (reset) begin
      e = '{0, 0, 0, 0, 0, 0};
      for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 0;
      m_off = 0; m_cnt = 0; m_len = 4; m_run = 0;
    end else begin
      e.d3 = m_buf[m_off % m_len];
      e.d2 = m_buf[(m_off + 1) % m_len];
      e.d1 = m_buf[(m_off + 2) % m_len];
      e.d0 = m_buf[(m_off + 3) % m_len];
      e.wrap = 0;
      if (bus.wr_en) m_buf[int'(bus.wr_addr)] = int'(bus.wr_data);
      if (bus.stop) begin
        m_run = 0;
        m_cnt = 0;
      end else if (bus.start) begin
        req   = int'(bus.len_cfg);
        m_len = (req < 4) ? 4 : ((req > MSG_LEN) ? MSG_LEN : req);
        m_run = 1; m_off = 0; m_cnt = 0;
      end else if (m_run == 1) begin
        m_cnt++;
        if (m_cnt == TICK_DIV) begin
          m_cnt = 0;
          m_off++;
          if (m_off == m_len) begin
            m_off  = 0;
            e.wrap = 1;
          end
        end
      end
      e.busy = m_run;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("dig3", int'(bus.dig3), e.d3);
    chk("dig2", int'(bus.dig2), e.d2);
    chk("dig1", int'(bus.dig1), e.d1);
    chk("dig0", int'(bus.dig0), e.d0);
    chk("busy", int'(bus.busy), e.busy);
    chk("wrap", int'(bus.wrap), e.wrap);
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 4'(data);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    bus.len_cfg = 5'(len);
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int wraps;
    clk = 1'b0; reset = 1'b1;
    n_chk = 0; n_bad = 0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len_cfg = '0; bus.start = 1'b0; bus.stop = 1'b0;
    m_off = 0; m_cnt = 0; m_len = 4; m_run = 0;
    for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 0;

    // reset then idle
    step(); step();
    reset = 1'b0;
    repeat (20) step();

    // six-character message, full lap with one wrap pulse
    for (int i = 0; i < 6; i++) wr(i, i + 1);
    pulse_start(6);
    chk("busy_after_start", int'(bus.busy), 1);
    wraps = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (bus.wrap) wraps++;
      if (i == 1) begin
        chk("win_a_d3", int'(bus.dig3), 1);
        chk("win_a_d0", int'(bus.dig0), 4);
      end
      if (i == 5) begin
        chk("win_b_d3", int'(bus.dig3), 2);
        chk("win_b_d0", int'(bus.dig0), 5);
      end
      if (i == 17) begin
        chk("win_c_d3", int'(bus.dig3), 5);
        chk("win_c_d0", int'(bus.dig0), 2);
      end
    end
    chk("wrap_at_lap", int'(bus.wrap), 1);
    chk("wrap_count", wraps, 1);
    step();
    chk("lap_d3", int'(bus.dig3), 1);
    chk("lap_d0", int'(bus.dig0), 4);
    chk("wrap_one_cycle", int'(bus.wrap), 0);

    // short length clamps to 4; write coincident with a scroll step
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    pulse_start(2);
    for (int i = 1; i <= 20; i++) begin
      if (i == 8) begin
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 4'd7;
      end
      step();
      bus.wr_en = 1'b0;
    end

    // long length clamps to 16
    for (int i = 6; i < MSG_LEN; i++) wr(i, i);
    pulse_start(20);
    repeat (70) step();

    // stop on a scroll-step edge keeps offset 0
    pulse_start(6);
    repeat (3) step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    step();
    chk("stop_edge_busy", int'(bus.busy), 0);
    chk("stop_edge_d3", int'(bus.dig3), 1);

    // stop and start together: stop wins, then write a displayed char
    pulse_start(6);
    repeat (9) step();
    bus.stop = 1'b1; bus.start = 1'b1; bus.len_cfg = 5'd6;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("stopstart_busy", int'(bus.busy), 0);
    wr(2, 9);
    chk("wr_not_yet_d3", int'(bus.dig3), 3);
    step();
    chk("wr_seen_d3", int'(bus.dig3), 9);
    repeat (6) step();
    chk("frozen_d3", int'(bus.dig3), 9);

    // reset mid-run, then restart shows a cleared buffer
    pulse_start(6);
    repeat (12) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_d3", int'(bus.dig3), 0);
    chk("rst_d0", int'(bus.dig0), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    pulse_start(6);
    repeat (5) step();
    chk("post_rst_d3", int'(bus.dig3), 0);
    chk("post_rst_busy", int'(bus.busy), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/message_scroll_ctrl.md
Name: message_scroll_ctrl

Overview:
Sequencer that feeds the four character inputs of the four-digit 7-segment LED driver. It holds a nibble-wide message buffer written by a host port. It presents a 4-character window of that buffer to digits 3..0 and scrolls the window by one character every TICK_DIV clocks while running. Sits between host/control logic and the LED driver's an3char..an0char inputs.

Parameters:
MSG_LEN, 16, buffer depth in characters (power of two, 4..16)
TICK_DIV, 25000000, clk cycles per scroll step (>=2)
CHAR_W, 4, character code width (LEDdecoder code)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  buffer write strobe, one char per cycle
wr_addr  in  4  buffer write address (log2 MSG_LEN)
wr_data  in  CHAR_W  character code to write
len_cfg  in  5  active message length, sampled on start
start  in  1  begin/restart scrolling (level sampled per cycle)
stop  in  1  halt scrolling, freeze window
dig3  out  CHAR_W  char for leftmost digit (to an3char)
dig2  out  CHAR_W  char for an2char
dig1  out  CHAR_W  char for an1char
dig0  out  CHAR_W  char for rightmost digit (to an0char)
busy  out  1  high while in RUN
wrap  out  1  one-cycle pulse when offset wraps to 0

Behaviour:
- Reset (reset=1 at clk edge): buffer all 0, offset=0, tick counter=0, active_len=4, state=IDLE; dig3..dig0=0, busy=0, wrap=0. Reset overrides every other input.
- Buffer: wr_en=1 writes wr_data to buf[wr_addr] at the edge. Writes are allowed in any state. Addresses >= active_len are stored but not displayed.
- Window: dig3=buf[offset], dig2=buf[(offset+1) mod active_len], dig1=buf[(offset+2) mod active_len], dig0=buf[(offset+3) mod active_len]. Outputs are registered. A change to offset or a write to a displayed address appears on dig* exactly 1 clk later.
- active_len: loaded from len_cfg on the start edge. len_cfg 0..3 is clamped to 4; len_cfg > MSG_LEN is clamped to MSG_LEN.
- States:
  - IDLE: busy=0, counter held at 0, window frozen at current offset. start=1 -> RUN, with offset=0, counter=0, active_len loaded.
  - RUN: busy=1, counter increments each clk. At counter==TICK_DIV-1: counter->0 and offset->offset+1, or 0 if offset==active_len-1. On that wrap, wrap=1 for exactly that following cycle. stop=1 -> IDLE; offset and window are kept; counter is cleared.
  - start=1 in RUN: restart, with offset=0, counter=0, active_len reloaded; no wrap pulse.
- Simultaneous events:
  - stop and start in the same cycle: stop wins.
  - A scroll step and a write in the same cycle: both take effect; the window uses the new data on the next cycle.
  - A scroll step and stop in the same cycle: stop wins; offset does not advance.
- Arithmetic: offset and window indices are computed modulo active_len, which is not necessarily a power of two; use a compare-and-subtract, not truncation. Counter width is clog2(TICK_DIV).
- Reset mid-RUN returns to IDLE with a cleared buffer; no wrap pulse is generated.

Test Plan:
(All with TICK_DIV=4, MSG_LEN=16.)
1. Reset then idle -> dig3..dig0=0,0,0,0; busy=0; wrap=0 for 20 cycles.
2. Write buf[0..5]=1,2,3,4,5,6; pulse start with len_cfg=6 -> busy=1; window 1,2,3,4 initially; after 4 clk it becomes 2,3,4,5; then 3,4,5,6; then 4,5,6,1; then 5,6,1,2; then 6,1,2,3.
3. Continue test 2 -> offset returns to 0 after the 24th run clk; wrap=1 for exactly 1 cycle; window becomes 1,2,3,4.
4. len_cfg=2 on start -> active_len=4; window shows buf[0..3]. len_cfg=20 -> active_len=16.
5. In RUN, assert stop and start together -> IDLE, offset frozen, busy=0. Then write buf[offset]=9 -> dig3=9 one clk later.
6. Assert reset mid-RUN at offset 3 -> next cycle: all digits 0, busy=0, wrap=0. Then start -> window shows 0,0,0,0.
